// File: rtl/box_compositor.sv
// box_compositor
//   Final compositing stage ahead of the VGA output register. It merges the fifteen box-pixel
//   layers with the piece and text layers into one 12-bit RGB pixel per clock. The layers used
//   depend on the game screen, which is latched once per frame. The block also owns the
//   frame-based blink timer, and it delays hsync/vsync/blank to match the pixel pipeline.
//
//   Optional feature macro: POPUP_DIM_EN
//     When defined, the play-field background outside the popup region is dimmed (each 4-bit
//     channel shifted right by one) in the PAUSE and GAMEOVER screens.
//
//   Parameters
//     BLINK_FRAMES : frames per blink half-period (1..255)
//     SYNC_DELAY   : cycles hsync/vsync/blank are delayed (box-stage latency + 1)
//
//   Ports
//     clk_in          : pixel clock
//     rst_n_in        : synchronous active-low reset
//     hsync_in        : hsync, aligned with hcount4/vcount
//     vsync_in        : vsync (active high), aligned with hcount4/vcount
//     blank_in        : blank, aligned with hcount4/vcount
//     game_state_in   : 0 START, 1 PLAY, 2 PAUSE, 3 GAMEOVER
//     option_sel_in   : 0 = option1 highlighted, 1 = option2
//     box_pixels_in   : fifteen 12-bit box pixels, one cycle after hcount4
//     piece_pixel_in  : grid/next/hold piece layer, same alignment as box pixels
//     text_pixel_in   : text/sprite layer, same alignment as box pixels
//     pixel_out       : composited RGB
//     hsync_out       : hsync_in delayed SYNC_DELAY
//     vsync_out       : vsync_in delayed SYNC_DELAY
//     blank_out       : blank_in delayed SYNC_DELAY
//     blink_phase_out : current blink phase
module box_compositor #(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned SYNC_DELAY   = 2
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic         blank_in,
  input  logic [1:0]   game_state_in,
  input  logic         option_sel_in,
  input  logic [179:0] box_pixels_in,
  input  logic [11:0]  piece_pixel_in,
  input  logic [11:0]  text_pixel_in,
  output logic [11:0]  pixel_out,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         blank_out,
  output logic         blink_phase_out
);

  typedef enum logic [1:0] {StStart, StPlay, StPause, StGameover} state_e;

  localparam logic [7:0] LAST_CNT = 8'(BLINK_FRAMES - 1);

  // Box slice indices
  localparam int unsigned B_START       = 0;
  localparam int unsigned B_START_BLINK = 1;
  localparam int unsigned B_POPUP       = 9;
  localparam int unsigned B_POPUP_SOLID = 10;
  localparam int unsigned B_OPT1        = 11;
  localparam int unsigned B_OPT1_SEL    = 12;
  localparam int unsigned B_OPT2        = 13;
  localparam int unsigned B_OPT2_SEL    = 14;

  logic [SYNC_DELAY-1:0] r_hsync_sr;
  logic [SYNC_DELAY-1:0] r_vsync_sr;
  logic [SYNC_DELAY-1:0] r_blank_sr;
  logic                  r_vsync_prev;
  state_e                r_state;
  logic                  r_option;
  logic [7:0]            r_frame_cnt;
  logic                  r_blink_phase;
  logic [11:0]           r_pixel;

  logic                  w_tick;
  logic                  w_blank_al;
  logic [11:0]           w_box [15];
  logic [11:0]           w_play_list [9];
  logic [11:0]           w_popup_list [5];
  logic [11:0]           w_play;
  logic [11:0]           w_popup;
  logic [11:0]           w_start;
  logic [11:0]           w_bg;
  logic [11:0]           w_pixel;

  assign w_tick = vsync_in & ~r_vsync_prev;

  // Blank seen by the pixel path must line up with box_pixels_in, one stage before the output.
  generate
    if (SYNC_DELAY > 1) begin : g_blank_tap
      assign w_blank_al = r_blank_sr[SYNC_DELAY-2];
    end else begin : g_blank_direct
      assign w_blank_al = blank_in;
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < 15; k++) begin
      w_box[k] = box_pixels_in[12*k +: 12];
    end
  end

  // Priority lists, highest priority at index 0.
  always_comb begin
    w_play_list[0] = text_pixel_in;
    w_play_list[1] = piece_pixel_in;
    for (int i = 2; i < 9; i++) begin
      w_play_list[i] = w_box[i];  // grid_outline .. hold_inner occupy slices 2..8
    end
    w_popup_list[0] = text_pixel_in;
    w_popup_list[1] = r_option ? w_box[B_OPT2_SEL] : w_box[B_OPT1_SEL];
    w_popup_list[2] = r_option ? w_box[B_OPT1]     : w_box[B_OPT2];
    w_popup_list[3] = w_box[B_POPUP];
    w_popup_list[4] = w_box[B_POPUP_SOLID];
  end

  // Walking from lowest to highest priority lets the first nonzero entry overwrite the rest.
  always_comb begin
    w_play = '0;
    for (int i = 8; i >= 0; i--) begin
      if (w_play_list[i] != 12'h000) w_play = w_play_list[i];
    end
    w_popup = '0;
    for (int i = 4; i >= 0; i--) begin
      if (w_popup_list[i] != 12'h000) w_popup = w_popup_list[i];
    end
    if (text_pixel_in != 12'h000) begin
      w_start = text_pixel_in;
    end else begin
      w_start = r_blink_phase ? w_box[B_START_BLINK] : w_box[B_START];
    end
  end

  always_comb begin
`ifdef POPUP_DIM_EN
    w_bg = {1'b0, w_play[11:9], 1'b0, w_play[7:5], 1'b0, w_play[3:1]};
`else
    w_bg = w_play;
`endif
  end

  always_comb begin
    w_pixel = '0;
    unique case (r_state)
      StStart: w_pixel = w_start;
      StPlay:  w_pixel = w_play;
      StPause, StGameover: begin
        w_pixel = (w_box[B_POPUP_SOLID] != 12'h000) ? w_popup : w_bg;
      end
      default: w_pixel = '0;
    endcase
    if (w_blank_al) w_pixel = '0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_hsync_sr    <= '0;
      r_vsync_sr    <= '0;
      r_blank_sr    <= '0;
      r_vsync_prev  <= 1'b0;
      r_state       <= StStart;
      r_option      <= 1'b0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_pixel       <= '0;
    end else begin
      r_hsync_sr[0] <= hsync_in;
      r_vsync_sr[0] <= vsync_in;
      r_blank_sr[0] <= blank_in;
      for (int i = 1; i < int'(SYNC_DELAY); i++) begin
        r_hsync_sr[i] <= r_hsync_sr[i-1];
        r_vsync_sr[i] <= r_vsync_sr[i-1];
        r_blank_sr[i] <= r_blank_sr[i-1];
      end
      r_vsync_prev <= vsync_in;
      r_pixel      <= w_pixel;
      if (w_tick) begin
        r_state  <= state_e'(game_state_in);
        r_option <= option_sel_in;
        // A screen change restarts the blink so the new screen opens in the visible phase.
        if (state_e'(game_state_in) != r_state) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= 1'b1;
        end else if (r_frame_cnt == LAST_CNT) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  assign pixel_out       = r_pixel;
  assign hsync_out       = r_hsync_sr[SYNC_DELAY-1];
  assign vsync_out       = r_vsync_sr[SYNC_DELAY-1];
  assign blank_out       = r_blank_sr[SYNC_DELAY-1];
  assign blink_phase_out = r_blink_phase;

endmodule
